// File: rtl/dbi_cmd_seq.sv
// dbi_cmd_seq
//   Turns the configuration registers into a DBI byte stream for the PHY.
//   The first run after reset sends soft-reset and display-on. Every frame
//   then sends column-address set, row-address set and memory-write, and
//   forwards the pixel bytes from the upstream stream.
//
// Optional feature (compile-time macro):
//   DBI_SEQ_RST_WAIT_EN  adds a RST_WAIT_CYC-cycle pause after soft-reset.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   addr_*_i                   command opcodes (sampled when a frame starts)
//   status_i                   bit0 = run
//   cmd_{s,e}_{col,row}_i      drawing window (sampled when a frame starts)
//   pxl_data_i/vld_i/rdy_o     upstream pixel byte stream
//   tx_data_o/dcx_o/vld_o      DBI byte stream (dcx: 0 command, 1 data)
//   tx_rdy_i                   PHY ready
//   frame_done_o               pulse on the last pixel-byte handshake
//   win_err_o                  pulse when a frame is skipped (bad window)
//
// Handshake: a byte moves when valid & ready are both high in a cycle.
// Valid never drops and data/dcx never change until that happens.
module dbi_cmd_seq #(
    parameter int DATA_W       = 8,
    parameter int PXL_BYTES    = 2,
    parameter int RST_WAIT_CYC = 120
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] addr_soft_rst_i,
    input  logic [DATA_W-1:0] addr_disp_on_i,
    input  logic [DATA_W-1:0] addr_col_i,
    input  logic [DATA_W-1:0] addr_row_i,
    input  logic [DATA_W-1:0] addr_mem_wr_i,
    input  logic [DATA_W-1:0] status_i,
    input  logic [DATA_W-1:0] cmd_s_col_i,
    input  logic [DATA_W-1:0] cmd_e_col_i,
    input  logic [DATA_W-1:0] cmd_s_row_i,
    input  logic [DATA_W-1:0] cmd_e_row_i,
    input  logic [DATA_W-1:0] pxl_data_i,
    input  logic              pxl_vld_i,
    output logic              pxl_rdy_o,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_dcx_o,
    output logic              tx_vld_o,
    input  logic              tx_rdy_i,
    output logic              frame_done_o,
    output logic              win_err_o
);

    typedef enum logic [3:0] {
        IDLE, SRST, RST_WAIT, DON, CCMD, CPAR, RCMD, RPAR, MCMD, PIXEL
    } state_e;

    state_e            state_q, state_d;
    logic              init_done_q, init_done_d;
    logic [16:0]       cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [DATA_W-1:0] op_don_q, op_don_d, op_col_q, op_col_d;
    logic [DATA_W-1:0] op_row_q, op_row_d, op_mwr_q, op_mwr_d;
    logic [DATA_W-1:0] s_col_q, s_col_d, e_col_q, e_col_d;
    logic [DATA_W-1:0] s_row_q, s_row_d, e_row_q, e_row_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_dcx_q, tx_dcx_d, tx_vld_q, tx_vld_d;
    logic              win_err_q, win_err_d;

`ifdef DBI_SEQ_RST_WAIT_EN
    localparam int WAIT_W = $clog2(RST_WAIT_CYC + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;
`else
    localparam int unused_rst_wait_cyc = RST_WAIT_CYC;
`endif

    logic              run, tx_hs, pxl_hs, win_bad, start_frame, frame_done;
    logic [DATA_W:0]   col_n, row_n;
    logic [2*DATA_W+1:0] pix_n;
    logic [16:0]       cnt_load;
    logic              unused_status;

    assign run           = status_i[0];
    assign unused_status = ^status_i[DATA_W-1:1];
    assign tx_hs         = tx_vld_q & tx_rdy_i;
    assign pxl_hs        = pxl_vld_i & tx_rdy_i;
    assign win_bad       = (cmd_e_col_i < cmd_s_col_i) || (cmd_e_row_i < cmd_s_row_i);

    // Factors are one bit wider than the coordinates so a full 0..max
    // window (max+1 pixels) does not wrap.
    assign col_n    = {1'b0, e_col_q} - {1'b0, s_col_q} + {{DATA_W{1'b0}}, 1'b1};
    assign row_n    = {1'b0, e_row_q} - {1'b0, s_row_q} + {{DATA_W{1'b0}}, 1'b1};
    assign pix_n    = {{(DATA_W+1){1'b0}}, col_n} * {{(DATA_W+1){1'b0}}, row_n};
    assign cnt_load = 17'(32'(pix_n) * 32'(PXL_BYTES) - 32'd1);

    // Address parameter bytes: 0x00, start, 0x00, end.
    function automatic logic [DATA_W-1:0] par_byte(input logic [1:0] idx,
                                                   input logic [DATA_W-1:0] s,
                                                   input logic [DATA_W-1:0] e);
        logic [DATA_W-1:0] b;
        b = '0;
        if (idx == 2'd1) b = s;
        else if (idx == 2'd3) b = e;
        return b;
    endfunction

    always_comb begin
        state_d     = state_q;
        init_done_d = init_done_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        op_don_d    = op_don_q;
        op_col_d    = op_col_q;
        op_row_d    = op_row_q;
        op_mwr_d    = op_mwr_q;
        s_col_d     = s_col_q;
        e_col_d     = e_col_q;
        s_row_d     = s_row_q;
        e_row_d     = e_row_q;
        tx_data_d   = tx_data_q;
        tx_dcx_d    = tx_dcx_q;
        tx_vld_d    = tx_vld_q;
        win_err_d   = 1'b0;
        start_frame = 1'b0;
        frame_done  = 1'b0;
`ifdef DBI_SEQ_RST_WAIT_EN
        wait_d      = wait_q;
`endif
        case (state_q)
            IDLE: start_frame = run;
            SRST: if (tx_hs) begin
`ifdef DBI_SEQ_RST_WAIT_EN
                state_d  = RST_WAIT;
                wait_d   = '0;
                tx_vld_d = 1'b0;
`else
                state_d   = DON;
                tx_data_d = op_don_q;
                tx_dcx_d  = 1'b0;
                tx_vld_d  = 1'b1;
`endif
            end
`ifdef DBI_SEQ_RST_WAIT_EN
            RST_WAIT: begin
                if (wait_q == WAIT_W'(RST_WAIT_CYC - 1)) begin
                    state_d   = DON;
                    tx_data_d = op_don_q;
                    tx_dcx_d  = 1'b0;
                    tx_vld_d  = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
`endif
            DON: if (tx_hs) begin
                init_done_d = 1'b1;
                state_d     = CCMD;
                tx_data_d   = op_col_q;
                tx_dcx_d    = 1'b0;
            end
            CCMD, RCMD: if (tx_hs) begin
                state_d   = (state_q == CCMD) ? CPAR : RPAR;
                idx_d     = 2'd0;
                tx_data_d = '0;
                tx_dcx_d  = 1'b1;
            end
            CPAR: if (tx_hs) begin
                if (idx_q == 2'd3) begin
                    state_d   = RCMD;
                    tx_data_d = op_row_q;
                    tx_dcx_d  = 1'b0;
                end else begin
                    idx_d     = idx_q + 2'd1;
                    tx_data_d = par_byte(idx_q + 2'd1, s_col_q, e_col_q);
                end
            end
            RPAR: if (tx_hs) begin
                if (idx_q == 2'd3) begin
                    state_d   = MCMD;
                    tx_data_d = op_mwr_q;
                    tx_dcx_d  = 1'b0;
                end else begin
                    idx_d     = idx_q + 2'd1;
                    tx_data_d = par_byte(idx_q + 2'd1, s_row_q, e_row_q);
                end
            end
            MCMD: if (tx_hs) begin
                state_d  = PIXEL;
                cnt_d    = cnt_load;
                tx_vld_d = 1'b0;   // pixel phase drives the outputs directly
            end
            PIXEL: if (pxl_hs) begin
                if (cnt_q == '0) begin
                    frame_done = 1'b1;
                    if (run) start_frame = 1'b1;
                    else     state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q - 17'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame start: check the live window, then snapshot everything so
        // later register writes only affect the next frame.
        if (start_frame) begin
            if (win_bad) begin
                win_err_d = 1'b1;
                state_d   = IDLE;
                tx_vld_d  = 1'b0;
            end else begin
                op_don_d  = addr_disp_on_i;
                op_col_d  = addr_col_i;
                op_row_d  = addr_row_i;
                op_mwr_d  = addr_mem_wr_i;
                s_col_d   = cmd_s_col_i;
                e_col_d   = cmd_e_col_i;
                s_row_d   = cmd_s_row_i;
                e_row_d   = cmd_e_row_i;
                state_d   = init_done_q ? CCMD : SRST;
                tx_data_d = init_done_q ? addr_col_i : addr_soft_rst_i;
                tx_dcx_d  = 1'b0;
                tx_vld_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            init_done_q <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= '0;
            op_don_q    <= '0;
            op_col_q    <= '0;
            op_row_q    <= '0;
            op_mwr_q    <= '0;
            s_col_q     <= '0;
            e_col_q     <= '0;
            s_row_q     <= '0;
            e_row_q     <= '0;
            tx_data_q   <= '0;
            tx_dcx_q    <= 1'b0;
            tx_vld_q    <= 1'b0;
            win_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_done_q <= init_done_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            op_don_q    <= op_don_d;
            op_col_q    <= op_col_d;
            op_row_q    <= op_row_d;
            op_mwr_q    <= op_mwr_d;
            s_col_q     <= s_col_d;
            e_col_q     <= e_col_d;
            s_row_q     <= s_row_d;
            e_row_q     <= e_row_d;
            tx_data_q   <= tx_data_d;
            tx_dcx_q    <= tx_dcx_d;
            tx_vld_q    <= tx_vld_d;
            win_err_q   <= win_err_d;
        end
    end

`ifdef DBI_SEQ_RST_WAIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_q <= '0;
        else        wait_q <= wait_d;
    end
`endif

    assign tx_data_o    = (state_q == PIXEL) ? pxl_data_i : tx_data_q;
    assign tx_dcx_o     = (state_q == PIXEL) ? 1'b1       : tx_dcx_q;
    assign tx_vld_o     = (state_q == PIXEL) ? pxl_vld_i  : tx_vld_q;
    assign pxl_rdy_o    = (state_q == PIXEL) & tx_rdy_i;
    assign frame_done_o = frame_done;
    assign win_err_o    = win_err_q;

endmodule

// File: tb/tb_dbi_cmd_seq.sv
// Testbench for dbi_cmd_seq: a reference model expands each frame request
// into the DBI byte sequence it must produce; a monitor compares every
// transmitted byte against that expectation in order.
module tb_dbi_cmd_seq;
    localparam int DATA_W       = 8;
    localparam int PXL_BYTES    = 2;
    localparam int RST_WAIT_CYC = 120;
`ifdef DBI_SEQ_RST_WAIT_EN
    localparam int EXP_GAP = RST_WAIT_CYC;
`else
    localparam int EXP_GAP = 0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] addr_soft_rst_i, addr_disp_on_i, addr_col_i;
    logic [DATA_W-1:0] addr_row_i, addr_mem_wr_i, status_i;
    logic [DATA_W-1:0] cmd_s_col_i, cmd_e_col_i, cmd_s_row_i, cmd_e_row_i;
    logic [DATA_W-1:0] pxl_data_i;
    logic              pxl_vld_i, pxl_rdy_o;
    logic [DATA_W-1:0] tx_data_o;
    logic              tx_dcx_o, tx_vld_o, tx_rdy_i;
    logic              frame_done_o, win_err_o;

    initial forever #5 clk = ~clk;

    dbi_cmd_seq #(.DATA_W(DATA_W), .PXL_BYTES(PXL_BYTES), .RST_WAIT_CYC(RST_WAIT_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .addr_soft_rst_i(addr_soft_rst_i), .addr_disp_on_i(addr_disp_on_i),
        .addr_col_i(addr_col_i), .addr_row_i(addr_row_i), .addr_mem_wr_i(addr_mem_wr_i),
        .status_i(status_i),
        .cmd_s_col_i(cmd_s_col_i), .cmd_e_col_i(cmd_e_col_i),
        .cmd_s_row_i(cmd_s_row_i), .cmd_e_row_i(cmd_e_row_i),
        .pxl_data_i(pxl_data_i), .pxl_vld_i(pxl_vld_i), .pxl_rdy_o(pxl_rdy_o),
        .tx_data_o(tx_data_o), .tx_dcx_o(tx_dcx_o), .tx_vld_o(tx_vld_o), .tx_rdy_i(tx_rdy_i),
        .frame_done_o(frame_done_o), .win_err_o(win_err_o)
    );

    // ---------------- scoreboard state ----------------
    logic [DATA_W:0]   exp_q[$];   // {dcx, byte}
    logic [DATA_W-1:0] pxl_q[$];   // pixel bytes still to feed upstream
    int n_chk = 0, n_pass = 0;
    int fd_cnt = 0, we_cnt = 0, pix_cnt = 0, vld_cyc = 0;
    int exp_fd = 0, exp_we = 0;
    bit bp_en = 1'b0;
    bit model_init = 1'b0;
    logic drv_pop;
    logic stall = 1'b0;
    logic [DATA_W:0] held = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Expands one frame into its byte sequence using the current inputs.
    task automatic push_frame(input int sc, input int ec, input int sr, input int er);
        int n;
        logic [DATA_W-1:0] b;
        if (!model_init) begin
            exp_q.push_back({1'b0, addr_soft_rst_i});
            exp_q.push_back({1'b0, addr_disp_on_i});
            model_init = 1'b1;
        end
        exp_q.push_back({1'b0, addr_col_i});
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, 8'(sc)});
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, 8'(ec)});
        exp_q.push_back({1'b0, addr_row_i});
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, 8'(sr)});
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, 8'(er)});
        exp_q.push_back({1'b0, addr_mem_wr_i});
        n = (ec - sc + 1) * (er - sr + 1) * PXL_BYTES;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            pxl_q.push_back(b);
            exp_q.push_back({1'b1, b});
        end
        exp_fd++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_window(input int sc, input int ec, input int sr, input int er);
        cmd_s_col_i = 8'(sc);
        cmd_e_col_i = 8'(ec);
        cmd_s_row_i = 8'(sr);
        cmd_e_row_i = 8'(er);
    endtask

    task automatic rand_opcodes();
        addr_col_i    = 8'($urandom);
        addr_row_i    = 8'($urandom);
        addr_mem_wr_i = 8'($urandom);
    endtask

    task automatic pulse_run();
        @(posedge clk); #1 status_i = {7'($urandom), 1'b1};
        @(posedge clk); #1 status_i = {7'($urandom), 1'b0};
    endtask

    task automatic wait_pix(input string name, input int target);
        int budget;
        budget = 5000;
        while (pix_cnt < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (pix_cnt < target) check({name, "_pixel_timeout"}, 32'(pix_cnt), 32'(target));
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 20000;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (exp_q.size() != 0) begin
            check({name, "_drain_timeout"}, 32'(exp_q.size()), 0);
            exp_q.delete();
            pxl_q.delete();
        end
        repeat (5) @(negedge clk);
        check({name, "_frame_done_count"}, 32'(fd_cnt), 32'(exp_fd));
    endtask

    // Upstream pixel source and PHY ready generator.
    initial begin
        pxl_vld_i  = 1'b0;
        pxl_data_i = '0;
        tx_rdy_i   = 1'b1;
        forever begin
            @(negedge clk);
            drv_pop = pxl_vld_i && pxl_rdy_o;
            if (drv_pop && pxl_q.size() > 0) void'(pxl_q.pop_front());
            @(posedge clk);
            #1;
            tx_rdy_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pxl_q.size() == 0) begin
                pxl_vld_i  = 1'b0;
                pxl_data_i = 8'($urandom);
            end else if (pxl_vld_i && !drv_pop) begin
                pxl_vld_i = 1'b1;   // held until accepted
            end else if (!bp_en || $urandom_range(0, 3) != 0) begin
                pxl_vld_i  = 1'b1;
                pxl_data_i = pxl_q[0];
            end else begin
                pxl_vld_i  = 1'b0;
                pxl_data_i = 8'($urandom);
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [DATA_W:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
                continue;
            end
            if (stall) check("hold_while_stalled", {tx_vld_o, tx_dcx_o, tx_data_o}, {1'b1, held});
            if (tx_vld_o) vld_cyc++;
            if (tx_vld_o && tx_rdy_i) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_tx_byte: got dcx=%0d data=0x%0h, required no byte (t=%0t)",
                             tx_dcx_o, tx_data_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", {tx_dcx_o, tx_data_o}, e);
                end
            end
            if (pxl_vld_i && pxl_rdy_o) pix_cnt++;
            if (frame_done_o) fd_cnt++;
            if (win_err_o) we_cnt++;
            stall = tx_vld_o && !tx_rdy_i;
            held  = {tx_dcx_o, tx_data_o};
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no end of test, required finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int sc, ec, sr, er, gap, we0, vld0, p0;
        bit found;
        rst_n = 1'b0;
        status_i = '0;
        addr_soft_rst_i = 8'h01; addr_disp_on_i = 8'h29;
        addr_col_i = 8'h2A; addr_row_i = 8'h2B; addr_mem_wr_i = 8'h2C;
        set_window(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_tx_vld", tx_vld_o, 0);
        check("rst_tx_data", tx_data_o, 0);
        check("rst_tx_dcx", tx_dcx_o, 0);
        check("rst_pxl_rdy", pxl_rdy_o, 0);
        check("rst_frame_done", frame_done_o, 0);
        check("rst_win_err", win_err_o, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Init + 1x1 frame, then a chained 4x2 frame with run held high.
        push_frame(0, 0, 0, 0);
        @(posedge clk); #1 status_i = 8'h01;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (tx_vld_o && tx_rdy_i && !tx_dcx_o && tx_data_o == 8'h01) found = 1'b1;
        end
        check("srst_handshake_seen", found, 1);
        gap = 0;
        do begin
            @(negedge clk);
            if (!tx_vld_o) gap++;
        end while (!tx_vld_o && gap < 1000);
        check("rst_wait_gap", gap, EXP_GAP);
        wait_pix("frame_a", 1);
        set_window(2, 5, 1, 2);
        push_frame(2, 5, 1, 2);
        wait_pix("frame_b", 3);
        status_i = 8'h00;
        drain("init_and_second");

        // Random windows under backpressure; one frame sees an e_col write.
        bp_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            sc = $urandom_range(0, 20);
            ec = sc + $urandom_range((k == 2) ? 2 : 0, 5);
            sr = $urandom_range(0, 20);
            er = sr + $urandom_range(0, 4);
            rand_opcodes();
            set_window(sc, ec, sr, er);
            push_frame(sc, ec, sr, er);
            p0 = pix_cnt;
            pulse_run();
            if (k == 2) begin
                wait_pix("mid_write", p0 + 1);
                cmd_e_col_i = 8'($urandom);
            end
            drain("random_bp");
        end

        // Full-width and full-height windows, and a window at the top corner.
        bp_en = 1'b0;
        set_window(0, 255, 3, 3);    push_frame(0, 255, 3, 3);    pulse_run(); drain("full_width");
        set_window(7, 7, 0, 255);    push_frame(7, 7, 0, 255);    pulse_run(); drain("full_height");
        set_window(255, 255, 255, 255); push_frame(255, 255, 255, 255); pulse_run(); drain("corner");

        // Invalid windows: skipped with a single error pulse, nothing sent.
        set_window(10, 3, 0, 0);
        we0 = we_cnt; vld0 = vld_cyc;
        pulse_run(); exp_we++;
        repeat (20) @(negedge clk);
        check("bad_col_win_err", 32'(we_cnt), 32'(we0 + 1));
        check("bad_col_no_tx", 32'(vld_cyc), 32'(vld0));
        set_window(0, 0, 5, 4);
        we0 = we_cnt; vld0 = vld_cyc;
        pulse_run(); exp_we++;
        repeat (20) @(negedge clk);
        check("bad_row_win_err", 32'(we_cnt), 32'(we0 + 1));
        check("bad_row_no_tx", 32'(vld_cyc), 32'(vld0));
        set_window(4, 6, 2, 3); push_frame(4, 6, 2, 3); pulse_run(); drain("after_bad_win");

        // Reset in the middle of the pixel phase, then a run re-sends init.
        bp_en = 1'b1;
        set_window(1, 6, 2, 4);
        push_frame(1, 6, 2, 4);
        p0 = pix_cnt;
        pulse_run();
        wait_pix("pre_reset", p0 + 2);
        @(posedge clk); #3;
        rst_n = 1'b0;
        exp_q.delete();
        pxl_q.delete();
        exp_fd--;
        model_init = 1'b0;
        #1;
        check("midrst_tx_vld", tx_vld_o, 0);
        check("midrst_tx_data", tx_data_o, 0);
        check("midrst_tx_dcx", tx_dcx_o, 0);
        check("midrst_pxl_rdy", pxl_rdy_o, 0);
        check("midrst_frame_done", frame_done_o, 0);
        check("midrst_win_err", win_err_o, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        addr_soft_rst_i = 8'h01; addr_disp_on_i = 8'h29;
        set_window(0, 2, 0, 1);
        push_frame(0, 2, 0, 1);
        pulse_run();
        drain("after_reset");

        check("win_err_total", 32'(we_cnt), 32'(exp_we));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
